// File: rtl/layer_sequencer_pkg.sv
// Shared types and helpers for the layer sequencer control slice.
package slac_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_W,
    WAIT_W,
    LOAD_A,
    WAIT_A,
    START,
    COMPUTE,
    GAP,
    DRAIN_REQ,
    DRAIN_WAIT,
    DRAIN_OUT,
    DONE
  } seq_state_t;

  localparam int unsigned CNT_W = 32;

  // Bits needed for a counter that spans 0..n-1 (never narrower than 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/psum_drain_unit.sv
// Reads NUM_PSUM words from the psum GLB and presents each one on a ready/valid stream.
module psum_drain_unit
  import slac_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned ADDR_BITWIDTH = 10,
  parameter int unsigned NUM_PSUM      = 25,
  parameter int unsigned GLB_RD_LAT    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     finished,
  output logic                     read_req_psum,
  output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum,
  output logic                     out_valid,
  output logic [DATA_BITWIDTH-1:0] out_data,
  input  logic                     out_ready
);

  localparam int unsigned IDX_W = cnt_width(NUM_PSUM);
  localparam int unsigned LAT_W = cnt_width(GLB_RD_LAT);

  seq_state_t         state, state_next;
  logic [IDX_W-1:0]   idx;
  logic [LAT_W-1:0]   lat_cnt;
  logic               lat_last;
  logic               last_word;

  assign lat_last  = (lat_cnt == LAT_W'(GLB_RD_LAT - 1));
  assign last_word = (idx == IDX_W'(NUM_PSUM - 1));

  always_comb begin
    state_next = state;
    finished   = 1'b0;
    case (state)
      IDLE:       if (start) state_next = DRAIN_REQ;
      DRAIN_REQ:  state_next = DRAIN_WAIT;
      DRAIN_WAIT: if (lat_last) state_next = DRAIN_OUT;
      DRAIN_OUT: begin
        if (out_ready) begin
          state_next = last_word ? IDLE : DRAIN_REQ;
          finished   = last_word;
        end
      end
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      lat_cnt  <= '0;
      out_data <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= (state == DRAIN_WAIT && !lat_last) ? lat_cnt + 1'b1 : '0;
      if (state == DRAIN_WAIT && lat_last)
        out_data <= r_data_psum;
      if (state == DRAIN_OUT && out_ready)
        idx <= last_word ? '0 : idx + 1'b1;
    end
  end

  assign read_req_psum = (state == DRAIN_REQ);
  assign r_addr_psum   = (state != IDLE) ? ADDR_BITWIDTH'(idx) : '0;
  assign out_valid     = (state == DRAIN_OUT);

endmodule

// File: rtl/layer_sequencer.sv
// Control FSM for one convolution layer pass: spad loads, NUM_ITER computes, psum drain.
module layer_sequencer
  import slac_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH  = 16,
  parameter int unsigned ADDR_BITWIDTH  = 10,
  parameter int unsigned NUM_PSUM       = 25,
  parameter int unsigned ITER_BITWIDTH  = 4,
  parameter int unsigned PULSE_CYCLES   = 2,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned GLB_RD_LAT     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [ITER_BITWIDTH-1:0] num_iter,
  output logic                     load_spad_ctrl_wght,
  output logic                     load_spad_ctrl_iact,
  input  logic                     load_done,
  output logic                     pe_start,
  input  logic                     compute_done,
  output logic                     read_req_psum,
  output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum,
  output logic                     out_valid,
  output logic [DATA_BITWIDTH-1:0] out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [CNT_W-1:0]         total_cycles,
  output logic [CNT_W-1:0]         compute_cycles
);

  localparam int unsigned PH_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned PH_W   = cnt_width(PH_MAX);
  localparam int unsigned TO_W   = cnt_width(TIMEOUT_CYCLES);

  seq_state_t             state, state_next;
  logic [PH_W-1:0]        phase_cnt;
  logic [TO_W-1:0]        wait_cnt;
  logic [ITER_BITWIDTH-1:0] iter_cnt, num_iter_q;
  logic [ITER_BITWIDTH:0] iter_inc;
  logic                   load_prev, comp_prev, load_edge, comp_edge;
  logic                   pulse_last, gap_last, wait_last, to_fire;
  logic                   drain_start, drain_finished;

  assign load_edge  = load_done & ~load_prev;
  assign comp_edge  = compute_done & ~comp_prev;
  assign pulse_last = (phase_cnt == PH_W'(PULSE_CYCLES - 1));
  assign gap_last   = (phase_cnt == PH_W'(GAP_CYCLES - 1));
  assign wait_last  = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign iter_inc   = {1'b0, iter_cnt} + 1'b1;

  // The whole drain is spent in DRAIN_REQ here; the drain unit steps through
  // its own REQ/WAIT/OUT states and reports back through drain_finished.
  always_comb begin
    state_next          = state;
    load_spad_ctrl_wght = 1'b0;
    load_spad_ctrl_iact = 1'b0;
    pe_start            = 1'b0;
    drain_start         = 1'b0;
    to_fire             = 1'b0;
    case (state)
      IDLE:   if (go) state_next = LOAD_W;
      LOAD_W: begin
        load_spad_ctrl_wght = 1'b1;
        if (pulse_last) state_next = WAIT_W;
      end
      WAIT_W: begin
        if (load_edge)      state_next = LOAD_A;
        else if (wait_last) begin to_fire = 1'b1; state_next = DONE; end
      end
      LOAD_A: begin
        load_spad_ctrl_iact = 1'b1;
        if (pulse_last) state_next = WAIT_A;
      end
      WAIT_A: begin
        if (load_edge) begin
          if (num_iter_q != '0) state_next = START;
          else begin state_next = DRAIN_REQ; drain_start = 1'b1; end
        end else if (wait_last) begin
          to_fire = 1'b1; state_next = DONE;
        end
      end
      START: begin
        pe_start = 1'b1;
        if (pulse_last) state_next = COMPUTE;
      end
      COMPUTE: begin
        if (comp_edge) begin
          if (iter_inc < {1'b0, num_iter_q}) state_next = GAP;
          else begin state_next = DRAIN_REQ; drain_start = 1'b1; end
        end else if (wait_last) begin
          to_fire = 1'b1; state_next = DONE;
        end
      end
      GAP:       if (gap_last) state_next = START;
      DRAIN_REQ: if (drain_finished) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      phase_cnt      <= '0;
      wait_cnt       <= '0;
      iter_cnt       <= '0;
      num_iter_q     <= '0;
      load_prev      <= 1'b0;
      comp_prev      <= 1'b0;
      timeout_err    <= 1'b0;
      total_cycles   <= '0;
      compute_cycles <= '0;
    end else begin
      state     <= state_next;
      phase_cnt <= (state_next == state) ? phase_cnt + 1'b1 : '0;
      wait_cnt  <= (state_next == state) ? wait_cnt + 1'b1 : '0;
      load_prev <= load_done;
      comp_prev <= compute_done;
      if (state == IDLE && go) begin
        num_iter_q     <= num_iter;
        iter_cnt       <= '0;
        timeout_err    <= 1'b0;
        total_cycles   <= '0;
        compute_cycles <= '0;
      end else begin
        if (to_fire)          timeout_err    <= 1'b1;
        if (state != IDLE)    total_cycles   <= total_cycles + 1'b1;
        if (state == COMPUTE) compute_cycles <= compute_cycles + 1'b1;
        if (state == COMPUTE && comp_edge) iter_cnt <= iter_cnt + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  psum_drain_unit #(
    .DATA_BITWIDTH (DATA_BITWIDTH),
    .ADDR_BITWIDTH (ADDR_BITWIDTH),
    .NUM_PSUM      (NUM_PSUM),
    .GLB_RD_LAT    (GLB_RD_LAT)
  ) u_drain (
    .clk           (clk),
    .reset         (reset),
    .start         (drain_start),
    .finished      (drain_finished),
    .read_req_psum (read_req_psum),
    .r_addr_psum   (r_addr_psum),
    .r_data_psum   (r_data_psum),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready)
  );

endmodule
